// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin owner of the shared 16-bit ALU.
// Grants one of NREQ requesters, registers its operands into the ALU, waits a
// per-opcode latency, then holds the captured result until the owner accepts it.
// Optional feature: define ALU_DIVZERO_CHK_EN to answer DIV/MOD by zero locally
// (result 16'hFFFF, overflow flag) without issuing the operation to the ALU.
module alu_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned SHORT_LAT = 1,
  parameter int unsigned LONG_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [6*NREQ-1:0]    req_opcode,
  input  logic [16*NREQ-1:0]   req_term1,
  input  logic [16*NREQ-1:0]   req_term2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 busy,
  output logic                 alu_enable,
  output logic [5:0]           alu_opcode,
  output logic [15:0]          alu_term1,
  output logic [15:0]          alu_term2,
  input  logic [15:0]          alu_result,
  input  logic                 alu_fl_zero,
  input  logic                 alu_fl_negative,
  input  logic                 alu_fl_carry,
  input  logic                 alu_fl_overflow,
  input  logic                 alu_done
);

  localparam int unsigned PtrW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MaxLat = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      alu_opcode_q, alu_opcode_d;
  logic [15:0]     alu_term1_q, alu_term1_d;
  logic [15:0]     alu_term2_q, alu_term2_d;
  logic [15:0]     result_q, result_d;
  logic [3:0]      flags_q, flags_d;

  logic            gnt_found;
  logic [PtrW-1:0] gnt_idx;
  logic [5:0]      sel_opcode;
  logic [15:0]     sel_term1;
  logic [15:0]     sel_term2;
  logic            sel_long;
  logic            owner_ready;

  // Distance of requester idx from the round-robin pointer, modulo NREQ.
  function automatic int unsigned rr_dist(input int unsigned idx, input logic [PtrW-1:0] ptr);
    int unsigned p;
    p = 32'(ptr);
    return (idx >= p) ? (idx - p) : (idx + NREQ - p);
  endfunction

  // Pick the valid requester closest to rr_ptr (rr_ptr itself first).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (rr_dist(i, rr_ptr_q) == k)) begin
          gnt_found = 1'b1;
          gnt_idx   = PtrW'(i);
        end
      end
    end
  end

  // Route the granted requester's opcode and operands.
  always_comb begin
    sel_opcode = '0;
    sel_term1  = '0;
    sel_term2  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_opcode = req_opcode[6*i +: 6];
        sel_term1  = req_term1[16*i +: 16];
        sel_term2  = req_term2[16*i +: 16];
      end
    end
  end

  // MUL, DIV and MOD take the long latency; everything else, listed or not, the short one.
  assign sel_long    = (sel_opcode == 6'h02) || (sel_opcode == 6'h03) || (sel_opcode == 6'h04);
  assign owner_ready = rsp_ready[owner_q];

`ifdef ALU_DIVZERO_CHK_EN
  logic sel_div_zero;
  assign sel_div_zero = ((sel_opcode == 6'h03) || (sel_opcode == 6'h04)) && (sel_term2 == 16'h0000);
`endif

  // Next-state logic for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_term1_d  = alu_term1_q;
    alu_term2_d  = alu_term2_q;
    result_d     = result_q;
    flags_d      = flags_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          owner_d = gnt_idx;
`ifdef ALU_DIVZERO_CHK_EN
          if (sel_div_zero) begin
            // Answered locally; the ALU registers keep their previous contents.
            result_d = 16'hFFFF;
            flags_d  = 4'b1000;
            state_d  = StResp;
          end else
`endif
          begin
            alu_opcode_d = sel_opcode;
            alu_term1_d  = sel_term1;
            alu_term2_d  = sel_term2;
            cnt_d        = sel_long ? CntW'(LONG_LAT) : CntW'(SHORT_LAT);
            state_d      = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == CntW'(1)) begin
          // Latency elapsed: wait here for alu_done if the ALU is late.
          if (alu_done) begin
            result_d = alu_result;
            flags_d  = {alu_fl_overflow, alu_fl_carry, alu_fl_negative, alu_fl_zero};
            cnt_d    = '0;
            state_d  = StResp;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (owner_ready) begin
          rr_ptr_d = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + PtrW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_term1_q  <= '0;
      alu_term2_q  <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_term1_q  <= alu_term1_d;
      alu_term2_q  <= alu_term2_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  // Accept strobe only in IDLE; gated by reset so every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    if (rst_b && (state_q == StIdle) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Response valid goes to the owner only.
  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign busy       = (state_q != StIdle);
  assign alu_enable = (state_q == StExec);
  assign alu_opcode = alu_opcode_q;
  assign alu_term1  = alu_term1_q;
  assign alu_term2  = alu_term2_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=2, SHORT_LAT=1, LONG_LAT=4).
// Honours ALU_DIVZERO_CHK_EN when the build defines it.
module tb_alu_arbiter;
  localparam int unsigned NREQ      = 2;
  localparam int unsigned SHORT_LAT = 1;
  localparam int unsigned LONG_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [11:0] req_opcode = '0;
  logic [31:0] req_term1 = '0;
  logic [31:0] req_term2 = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy, alu_enable;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_term1, alu_term2;
  logic [19:0] alu_out;
  logic        alu_done = 1'b1;

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .SHORT_LAT(SHORT_LAT), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_opcode(req_opcode),
    .req_term1(req_term1), .req_term2(req_term2), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_term1(alu_term1), .alu_term2(alu_term2),
    .alu_result(alu_out[15:0]), .alu_fl_zero(alu_out[16]), .alu_fl_negative(alu_out[17]),
    .alu_fl_carry(alu_out[18]), .alu_fl_overflow(alu_out[19]), .alu_done(alu_done)
  );

  // Behavioural ALU: returns {overflow, carry, negative, zero, result}.
  function automatic logic [19:0] alu_ref(input logic [5:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] sum, diff;
    logic [15:0] r;
    logic v, c, fz, fn;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    v = 1'b0;
    c = 1'b0;
    case (op)
      6'h00: begin r = sum[15:0]; c = sum[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      6'h01: begin r = diff[15:0]; c = diff[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
      6'h02: r = a * b;
      6'h03: r = (b == 16'h0) ? 16'hFFFF : a / b;
      6'h04: r = (b == 16'h0) ? a : a % b;
      6'h05: r = a;
      default: r = a ^ b;
    endcase
    fz = (r == 16'h0);
    fn = r[15];
    if (op == 6'h05) begin
      fz = (diff[15:0] == 16'h0);
      fn = diff[15];
      c  = diff[16];
      v  = (a[15] != b[15]) && (diff[15] != a[15]);
    end
    return {v, c, fn, fz, r};
  endfunction

  always_comb alu_out = alu_ref(alu_opcode, alu_term1, alu_term2);

  // Expected response of the arbiter for one operation, from the latency rules.
  task automatic exp_rsp(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] res, output logic [3:0] fl);
    logic [19:0] o;
    o   = alu_ref(op, a, b);
    res = o[15:0];
    fl  = o[19:16];
    lat = (op == 6'h02 || op == 6'h03 || op == 6'h04) ? int'(LONG_LAT) : int'(SHORT_LAT);
`ifdef ALU_DIVZERO_CHK_EN
    if ((op == 6'h03 || op == 6'h04) && b == 16'h0) begin
      lat = 0;
      res = 16'hFFFF;
      fl  = 4'b1000;
    end
`endif
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One full transaction: offer, accept, count EXEC cycles, check response, hold, handshake.
  task automatic txn(input string nm, input logic [1:0] vmask, input logic [11:0] ops,
                     input logic [31:0] t1s, input logic [31:0] t2s, input int bp,
                     input int exp_own, input int exp_lat, input logic [15:0] exp_res,
                     input logic [3:0] exp_fl);
    int en;
    bit seen;
    logic [1:0] oh;
    oh = 2'b01 << exp_own;
    @(negedge clk);
    req_valid  = vmask;
    req_opcode = ops;
    req_term1  = t1s;
    req_term2  = t2s;
    rsp_ready  = '0;
    #1;
    chk({nm, " ready"}, 64'(req_ready), 64'(oh));
    @(posedge clk);
    en = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
      else if (alu_enable) en++;
    end
    chk({nm, " seen"}, 64'(seen), 64'd1);
    chk({nm, " lat"}, 64'(en), 64'(exp_lat));
    chk({nm, " owner"}, 64'(rsp_valid), 64'(oh));
    chk({nm, " result"}, 64'(rsp_result), 64'(exp_res));
    chk({nm, " flags"}, 64'(rsp_flags), 64'(exp_fl));
    for (int c = 0; c < bp; c++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      #1;
      chk({nm, " hold"}, {rsp_valid, rsp_result, rsp_flags}, {oh, exp_res, exp_fl});
    end
    rsp_ready = oh;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = '0;
    model_ptr = (exp_own + 1) % int'(NREQ);
    #1;
    chk({nm, " idle"}, 64'({busy, rsp_valid}), 64'd0);
  endtask

  typedef struct {
    int          req;
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t       vecs[11];
  logic [5:0] op_pool[8];

  initial begin
    bit seen;
    int grants, bad;
    logic [1:0] oh;
    logic [11:0] ops;
    logic [31:0] t1s, t2s;

    vecs[0]  = '{0, 6'h00, 16'd3,    16'd4,    1, 16'd7,    4'b0000};
    vecs[1]  = '{1, 6'h02, 16'h0010, 16'h0010, 4, 16'h0100, 4'b0000};
    vecs[2]  = '{0, 6'h00, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b0101};
    vecs[3]  = '{1, 6'h00, 16'h7FFF, 16'h0001, 1, 16'h8000, 4'b1010};
    vecs[4]  = '{1, 6'h01, 16'd5,    16'd7,    1, 16'hFFFE, 4'b0110};
    vecs[5]  = '{0, 6'h03, 16'd100,  16'd7,    4, 16'd14,   4'b0000};
    vecs[6]  = '{1, 6'h04, 16'd100,  16'd7,    4, 16'd2,    4'b0000};
    vecs[7]  = '{0, 6'h3F, 16'h00FF, 16'h0F0F, 1, 16'h0FF0, 4'b0000};
    vecs[8]  = '{1, 6'h05, 16'd9,    16'd9,    1, 16'd9,    4'b0001};
    vecs[9]  = '{0, 6'h05, 16'd3,    16'd5,    1, 16'd3,    4'b0110};
`ifdef ALU_DIVZERO_CHK_EN
    vecs[10] = '{0, 6'h03, 16'd5,    16'd0,    0, 16'hFFFF, 4'b1000};
`else
    vecs[10] = '{0, 6'h03, 16'd5,    16'd0,    4, 16'hFFFF, 4'b0010};
`endif
    op_pool = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h3F, 6'h12};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {req_ready, rsp_valid, rsp_result, rsp_flags, busy, alu_enable,
                          alu_opcode, alu_term1, alu_term2}, 64'd0);
    rst_b = 1'b1;

    // Directed vectors, one requester at a time.
    foreach (vecs[i]) begin
      ops = '0; t1s = '0; t2s = '0;
      ops[6*vecs[i].req +: 6]  = vecs[i].op;
      t1s[16*vecs[i].req +: 16] = vecs[i].a;
      t2s[16*vecs[i].req +: 16] = vecs[i].b;
      txn($sformatf("vec%0d", i), 2'b01 << vecs[i].req, ops, t1s, t2s, i % 3, vecs[i].req,
          vecs[i].lat, vecs[i].res, vecs[i].fl);
    end

    // ALU late: EXEC holds until alu_done.
    @(negedge clk);
    alu_done = 1'b0;
    req_valid = 2'b01; req_opcode = '0; req_term1 = 32'h2; req_term2 = 32'h2;
    #1 chk("stall grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("stall enable", 64'({alu_enable, rsp_valid}), 64'b100);
    end
    alu_done = 1'b1;
    @(negedge clk);
    #1;
    chk("stall rsp", 64'({rsp_valid, rsp_result}), {46'd0, 2'b01, 16'd4});
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = '0;
    model_ptr = 1;

    // Backpressure with a competing requester and a non-owner rsp_ready.
    @(negedge clk);
    req_valid = 2'b01; req_opcode = '0;
    req_term1 = {16'h0001, 16'h1234}; req_term2 = {16'h0001, 16'h1111};
    #1 chk("bp grant0", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid != 2'b00) begin seen = 1'b1; break; end
      chk("bp busy no grant", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("bp seen", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp hold", {req_ready, rsp_valid, rsp_result, rsp_flags}, {2'b00, 2'b01, 16'h2345, 4'h0});
      @(negedge clk);
      #1;
    end
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    #1 chk("bp grant1", 64'(req_ready), 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0; rsp_ready = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid == 2'b10) begin
        seen = 1'b1;
        chk("bp result1", 64'(rsp_result), 64'd2);
        break;
      end
      @(negedge clk);
    end
    chk("bp seen1", 64'(seen), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = '0;
    model_ptr = 0;

    // Reset in the middle of a long operation.
    req_valid = 2'b01; req_opcode = 12'h002; req_term1 = 32'd3; req_term2 = 32'd3;
    #1 chk("mid grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1 chk("mid enable", 64'(alu_enable), 64'd1);
    rst_b = 1'b0;
    #1;
    chk("mid reset outputs", {req_ready, rsp_valid, rsp_result, rsp_flags, busy, alu_enable,
                              alu_opcode, alu_term1, alu_term2}, 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    model_ptr = 0;
    rsp_ready = 2'b11;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00 || busy) bad++;
    end
    chk("mid no response", 64'(bad), 64'd0);
    rsp_ready = '0;

    // Fairness: both requesters always valid, strict rotation from requester 0.
    @(negedge clk);
    req_valid = 2'b11; req_opcode = '0; req_term1 = 32'h00050001; req_term2 = 32'h00060002;
    rsp_ready = 2'b11;
    grants = 0;
    for (int c = 0; c < 100 && grants < 6; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        oh = 2'b01 << model_ptr;
        chk($sformatf("fair grant%0d", grants), 64'(req_ready), 64'(oh));
        model_ptr = (model_ptr + 1) % int'(NREQ);
        grants++;
      end
      if (grants < 6) @(negedge clk);
    end
    chk("fair count", 64'(grants), 64'd6);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    rsp_ready = '0;
    #1 chk("fair idle", 64'(busy), 64'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] vm;
      int own, lat;
      logic [15:0] res;
      logic [3:0] fl;
      vm = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        ops[6*r +: 6]   = op_pool[$urandom_range(0, 7)];
        t1s[16*r +: 16] = 16'($urandom);
        t2s[16*r +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      if (model_ptr == 0) own = vm[0] ? 0 : 1;
      else own = vm[1] ? 1 : 0;
      exp_rsp(ops[6*own +: 6], t1s[16*own +: 16], t2s[16*own +: 16], lat, res, fl);
      txn($sformatf("rand%0d", n), vm, ops, t1s, t2s, int'($urandom_range(0, 3)), own, lat,
          res, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
